// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared width, FSM state and number types for the prime trial divider
package prime_pkg;

    localparam int DEFAULT_WIDTH = 11;

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        DIV,
        CHK,
        EMIT,
        DONE
    } state_t;

    typedef logic [DEFAULT_WIDTH-1:0] num_t;

endpackage

// File: rtl/serial_mod.sv
// rtl/serial_mod.sv - restoring bit-serial remainder, one dividend bit per cycle
module serial_mod #(
    parameter int WIDTH = prime_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder,
    output logic             rdy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_rdy;

    // Shift one dividend bit into the partial remainder; a single conditional
    // subtract suffices because the partial remainder is always below the divisor.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] rem,
                                                  input logic             bit_in,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        sh = {rem, bit_in};
        if (sh >= {1'b0, d}) begin
            sh = sh - {1'b0, d};
        end
        return sh[WIDTH-1:0];
    endfunction

    // The go cycle performs the first step, so the remainder is ready WIDTH cycles after go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_rdy <= 1'b0;
        end else if (go) begin
            r_rem <= mod_step('0, dividend[WIDTH-1], divisor);
            r_quo <= dividend << 1;
            r_div <= divisor;
            r_cnt <= CW'(WIDTH - 1);
            r_rdy <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem <= mod_step(r_rem, r_quo[WIDTH-1], r_div);
            r_quo <= r_quo << 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_rdy <= 1'b1;
            end
        end
    end

    assign remainder = r_rem;
    assign rdy       = r_rdy;

endmodule

// File: rtl/prime_trial_divider.sv
// rtl/prime_trial_divider.sv - sweeps n=2..num_max, trial-divides each n, streams (n, prime); option PRIME_SKIP_EVEN_EN
module prime_trial_divider
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_max,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] number_checked,
    output logic             prime,
    output logic [WIDTH-1:0] number_of_primes
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_count;
    logic             r_prime;

    logic [WIDTH-1:0] w_dnext;
    logic [WIDTH-1:0] w_div_in;
    logic [WIDTH-1:0] w_rem;
    logic             w_rdy;
    logic             w_go;
    logic             w_even_skip;
    logic             w_d_past;
    logic             w_dnext_past;

    // True when d*d exceeds n, evaluated at full double width so it never overflows.
    function automatic logic sq_exceeds(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] n);
        logic [2*WIDTH-1:0] dd;
        dd = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
        return dd > {{WIDTH{1'b0}}, n};
    endfunction

`ifdef PRIME_SKIP_EVEN_EN
    assign w_even_skip = ~r_n[0] && (r_n != WIDTH'(2));
    assign w_dnext     = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
`else
    assign w_even_skip = 1'b0;
    assign w_dnext     = r_d + WIDTH'(1);
`endif

    assign w_d_past     = sq_exceeds(r_d, r_n);
    assign w_dnext_past = sq_exceeds(w_dnext, r_n);

    // In CHK the divisor register is still being advanced, so feed the next divisor directly.
    assign w_div_in = (r_state == CHK) ? w_dnext : r_d;

    serial_mod #(.WIDTH(WIDTH)) u_mod (
        .clk       (clk),
        .rst       (rst),
        .go        (w_go),
        .dividend  (r_n),
        .divisor   (w_div_in),
        .remainder (w_rem),
        .rdy       (w_rdy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (num_max < WIDTH'(2)) ? DONE : TEST;
                end
            end
            TEST: begin
                if (w_even_skip || w_d_past) begin
                    w_next = EMIT;
                end else begin
                    w_next = DIV;
                end
            end
            DIV: begin
                if (w_rdy) begin
                    w_next = CHK;
                end
            end
            CHK: begin
                if (w_rem == '0 || w_dnext_past) begin
                    w_next = EMIT;
                end else begin
                    w_next = DIV;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_next = (r_n == r_max) ? DONE : TEST;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state; go launches a division on entry to DIV.
    always_comb begin
        busy      = (r_state == TEST) || (r_state == DIV) || (r_state == CHK) || (r_state == EMIT);
        done      = (r_state == DONE);
        out_valid = (r_state == EMIT);
        w_go      = ((r_state == TEST) || (r_state == CHK)) && (w_next == DIV);
    end

    // Sweep datapath: bound latch, candidate n, divisor d, verdict and prime count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n     <= '0;
            r_d     <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_prime <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_max   <= num_max;
                        r_count <= '0;
                        if (num_max >= WIDTH'(2)) begin
                            r_n <= WIDTH'(2);
                            r_d <= WIDTH'(2);
                        end
                    end
                end
                TEST: begin
                    if (w_even_skip) begin
                        r_prime <= 1'b0;
                    end else if (w_d_past) begin
                        r_prime <= 1'b1;
                    end
                end
                CHK: begin
                    if (w_rem == '0) begin
                        r_prime <= 1'b0;
                    end else begin
                        r_d <= w_dnext;
                        if (w_dnext_past) begin
                            r_prime <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_count <= r_count + WIDTH'(r_prime);
                        if (r_n != r_max) begin
                            r_n <= r_n + WIDTH'(1);
                            r_d <= WIDTH'(2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign number_checked   = r_n;
    assign prime            = r_prime;
    assign number_of_primes = r_count;

endmodule

// File: tb/tb_prime_trial_divider.sv
// tb/tb_prime_trial_divider.sv - randomized self-checking bench against a plain-arithmetic prime model
module tb_prime_trial_divider;

    localparam int W     = 11;
    localparam int LIMIT = 120000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] num_max;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] number_checked;
    logic         prime;
    logic [W-1:0] number_of_primes;

    int errors = 0;
    int checks = 0;

    prime_trial_divider #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_max          (num_max),
        .busy             (busy),
        .done             (done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .number_checked   (number_checked),
        .prime            (prime),
        .number_of_primes (number_of_primes)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int i = 2; i * i <= n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int count_primes(input int m);
        int c = 0;
        for (int i = 2; i <= m; i++) c += int'(is_prime(i));
        return c;
    endfunction

    task automatic do_start(input int m);
        @(negedge clk);
        start   = 1'b1;
        num_max = W'(m);
        @(negedge clk);
        start   = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall 5 cycles at n=11, 3: stray start mid-sweep
    task automatic run_sweep(input int m, input int mode, input string name);
        int           exp_n   = 2;
        int           exp_cnt = 0;
        int           cycles  = 0;
        int           stall   = 0;
        bit           pending = 1'b0;
        logic [W-1:0] prev_n  = '0;
        logic         prev_p  = 1'b0;
        do_start(m);
        while (done !== 1'b1 && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
            checks++;
            if (number_of_primes !== W'(exp_cnt)) begin
                errors++;
                $display("FAIL %s running_count: got %0d want %0d", name, number_of_primes, exp_cnt);
            end
            if (pending) begin
                checks++;
                if (out_valid !== 1'b1 || number_checked !== prev_n || prime !== prev_p) begin
                    errors++;
                    $display("FAIL %s held_result: got v=%0b n=%0d p=%0b want v=1 n=%0d p=%0b",
                             name, out_valid, number_checked, prime, prev_n, prev_p);
                end
            end
            start = 1'b0;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid === 1'b1 && number_checked === W'(11) && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                3: begin
                    out_ready = 1'b1;
                    if (cycles == 40) begin
                        start   = 1'b1;
                        num_max = W'(3);
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (number_checked !== W'(exp_n) || prime !== is_prime(exp_n)) begin
                    errors++;
                    $display("FAIL %s result: got n=%0d p=%0b want n=%0d p=%0b",
                             name, number_checked, prime, exp_n, is_prime(exp_n));
                end
                exp_cnt += int'(is_prime(exp_n));
                exp_n++;
                pending = 1'b0;
            end else begin
                pending = (out_valid === 1'b1);
                prev_n  = number_checked;
                prev_p  = prime;
            end
        end
        start = 1'b0;
        checks++;
        if (cycles >= LIMIT) begin
            errors++;
            $display("FAIL %s timeout: got %0d cycles want done", name, cycles);
        end
        checks++;
        if (exp_n - 2 != m - 1) begin
            errors++;
            $display("FAIL %s result_count: got %0d want %0d", name, exp_n - 2, m - 1);
        end
        @(negedge clk);
        checks++;
        if (number_of_primes !== W'(count_primes(m)) || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s final: got cnt=%0d done=%0b busy=%0b want cnt=%0d done=1 busy=0",
                     name, number_of_primes, done, busy, count_primes(m));
        end
        if (mode == 2) begin
            checks++;
            if (stall != 5) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d want 5", name, stall);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        num_max   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, out_valid, prime} !== 4'b0 || number_checked !== '0 || number_of_primes !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got b=%0b d=%0b v=%0b p=%0b n=%0d c=%0d want all 0",
                     busy, done, out_valid, prime, number_checked, number_of_primes);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        for (int m = 0; m < 2; m++) begin
            do_start(m);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || number_of_primes !== '0) begin
                errors++;
                $display("FAIL degenerate_%0d: got d=%0b b=%0b v=%0b c=%0d want d=1 b=0 v=0 c=0",
                         m, done, busy, out_valid, number_of_primes);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL degenerate_hold_%0d: got v=%0b d=%0b want v=0 d=1", m, out_valid, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        out_ready = 1'b1;
        do_start(100);
        while (number_checked !== W'(50) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= LIMIT) begin
            errors++;
            $display("FAIL reset_mid_reach: got n=%0d want 50", number_checked);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, prime} !== 4'b0 || number_checked !== '0 || number_of_primes !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got b=%0b d=%0b v=%0b p=%0b n=%0d c=%0d want all 0",
                     busy, done, out_valid, prime, number_checked, number_of_primes);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got v=%0b b=%0b want 0 0", out_valid, busy);
        end
        run_sweep(7, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            run_sweep(int'($urandom_range(2, 150)), 1, "random");
        end
    endtask

    initial begin
        test_reset();
        run_sweep(10, 0, "small");
        test_degenerate();
        run_sweep(20, 2, "backpressure");
        run_sweep(1000, 0, "large");
        test_reset_mid();
        run_sweep(30, 3, "start_ignored");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
